kpn_add_process: RTL and testbench

- KPN process node placed directly upstream of the 16-bit token FIFOs (B=16, W=5).
- Consumes one token from each of two input FIFOs (A, B) and forms A+B.
- Produces one token into the output FIFO.
- Implements blocking-read / blocking-write Kahn semantics with a small FSM:
  - never reads an empty FIFO;
  - never writes a full FIFO;
  - never drops or duplicates a token.

---
 rtl/kpn_pkg.sv | 14 +
 rtl/kpn_add_process_if.sv | 28 ++
 rtl/kpn_token_alu.sv | 16 +
 rtl/kpn_add_process.sv | 92 +++++++++
 tb/tb_kpn_add_process.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kpn_pkg.sv
// Shared definitions for KPN process nodes: token/FIFO geometry and the
// common blocking-read / blocking-write state encoding.
package kpn_pkg;
    localparam int TOKEN_W = 16;
    localparam int FIFO_AW = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        CAPTURE  = 3'd2,
        WAIT_OUT = 3'd3,
        DONE     = 3'd4
    } kpn_state_t;
endpackage

// File: rtl/kpn_add_process_if.sv
// FIFO-side signals of a two-input, one-output KPN process node.
import kpn_pkg::*;

// Handshake: the node raises rd_a/rd_b for one cycle only when the matching
// empty flag was low, and the FIFO answers with data the following cycle;
// the node raises wr_out for one cycle only after seeing full_out low, with
// data_out stable during that cycle.
interface kpn_add_process_if #(parameter int B = TOKEN_W);
    logic         empty_a;
    logic         empty_b;
    logic [B-1:0] data_a;
    logic [B-1:0] data_b;
    logic         rd_a;
    logic         rd_b;
    logic         full_out;
    logic         wr_out;
    logic [B-1:0] data_out;

    modport master (
        input  empty_a, empty_b, data_a, data_b, full_out,
        output rd_a, rd_b, wr_out, data_out
    );

    modport slave (
        output empty_a, empty_b, data_a, data_b, full_out,
        input  rd_a, rd_b, wr_out, data_out
    );
endinterface

// File: rtl/kpn_token_alu.sv
// Combinational token operator: B-bit add that either wraps or saturates.
import kpn_pkg::*;

module kpn_token_alu #(
    parameter int B   = TOKEN_W,
    parameter int SAT = 0
) (
    input  logic [B-1:0] a,
    input  logic [B-1:0] b,
    output logic [B-1:0] y
);
    logic [B:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};
    assign y   = ((SAT != 0) && sum[B]) ? {B{1'b1}} : sum[B-1:0];
endmodule

// File: rtl/kpn_add_process.sv
// KPN adder node: blocking read of one token from each input FIFO, add,
// blocking write of the result. The state register is exported for debug.
import kpn_pkg::*;

module kpn_add_process #(
    parameter int B   = TOKEN_W,
    parameter int SAT = 0,
    parameter int CW  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    kpn_add_process_if.master     io,
    output logic                  busy,
    output logic [CW-1:0]         tokens_done,
    output kpn_state_t            state
);
    kpn_state_t    state_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [B-1:0]  dout_q, dout_d;
    logic [B-1:0]  result_q, result_d;
    logic [CW-1:0] cnt_d;
    logic          busy_d;
    logic [B-1:0]  alu_y;

    kpn_token_alu #(.B(B), .SAT(SAT)) u_alu (
        .a (io.data_a),
        .b (io.data_b),
        .y (alu_y)
    );

    always_comb begin
        state_d  = state;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        dout_d   = dout_q;
        result_d = result_q;
        cnt_d    = tokens_done;
        case (state)
            IDLE: begin
                // Both inputs must be available; a lone token waits.
                if (!io.empty_a && !io.empty_b) begin
                    rd_d    = 1'b1;
                    state_d = READ;
                end
            end
            READ:    state_d = CAPTURE;
            CAPTURE: begin
                result_d = alu_y;
                state_d  = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (!io.full_out) begin
                    wr_d    = 1'b1;
                    dout_d  = result_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = tokens_done + CW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            dout_q      <= '0;
            result_q    <= '0;
            tokens_done <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            dout_q      <= dout_d;
            result_q    <= result_d;
            tokens_done <= cnt_d;
            busy        <= busy_d;
        end
    end

    assign io.rd_a     = rd_q;
    assign io.rd_b     = rd_q;
    assign io.wr_out   = wr_q;
    assign io.data_out = dout_q;
endmodule

// File: tb/tb_kpn_add_process.sv
// Bench for kpn_add_process: wrapping and saturating instances run in
// lockstep on shared input FIFO models; outputs are scoreboarded.
import kpn_pkg::*;

module tb_kpn_add_process;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    kpn_add_process_if fif ();
    kpn_add_process_if sif ();

    logic        busy, busy_s;
    logic [15:0] tokens_done, tokens_done_s;
    kpn_state_t  state, state_s;

    assign sif.empty_a  = fif.empty_a;
    assign sif.empty_b  = fif.empty_b;
    assign sif.data_a   = fif.data_a;
    assign sif.data_b   = fif.data_b;
    assign sif.full_out = fif.full_out;

    kpn_add_process #(.B(16), .SAT(0), .CW(16)) dut (
        .clk (clk), .reset (reset), .io (fif),
        .busy (busy), .tokens_done (tokens_done), .state (state)
    );

    kpn_add_process #(.B(16), .SAT(1), .CW(16)) dut_sat (
        .clk (clk), .reset (reset), .io (sif),
        .busy (busy_s), .tokens_done (tokens_done_s), .state (state_s)
    );

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] exp_q[$];
    logic [15:0] exp_sat_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int wr_sat_cnt = 0;
    int last_rd_cyc = 0;
    int last_wr_cyc = 0;
    logic prev_rd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input FIFO model: pop on read strobe, data then stays valid for the next cycle.
    initial begin
        fif.empty_a = 1'b1;
        fif.empty_b = 1'b1;
        fif.data_a  = '0;
        fif.data_b  = '0;
        forever begin
            @(negedge clk);
            if (fif.rd_a) begin
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_a_on_empty: read strobe while FIFO A empty (cycle %0d)", cyc);
                end else fif.data_a = qa.pop_front();
            end
            if (fif.rd_b) begin
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_b_on_empty: read strobe while FIFO B empty (cycle %0d)", cyc);
                end else fif.data_b = qb.pop_front();
            end
            fif.empty_a = (qa.size() == 0);
            fif.empty_b = (qb.size() == 0);
        end
    end

    // Monitor: strobe shape checks and output scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (fif.rd_a || fif.rd_b) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                check("rd_pair_single", {fif.rd_a, fif.rd_b, prev_rd}, 3'b110);
            end
            if (fif.wr_out) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL wrap_unexpected_write: got 0x%0h with nothing expected", fif.data_out);
                end else check("wrap_data_out", fif.data_out, exp_q.pop_front());
            end
            if (sif.wr_out) begin
                wr_sat_cnt++;
                if (exp_sat_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sat_unexpected_write: got 0x%0h with nothing expected", sif.data_out);
                end else check("sat_data_out", sif.data_out, exp_sat_q.pop_front());
            end
        end
        prev_rd = fif.rd_a;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        exp_sat_q.delete();
        qa.delete();
        qb.delete();
        tick(2);
        reset = 1'b0;
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] e_wrap, input logic [15:0] e_sat);
        qa.push_back(a);
        qb.push_back(b);
        exp_q.push_back(e_wrap);
        exp_sat_q.push_back(e_sat);
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int k = 0;
        while (wr_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check(name, wr_cnt, target);
    endtask

    task automatic wait_state(input kpn_state_t s, input int budget, input string name);
        int k = 0;
        while (state != s && k < budget) begin
            tick();
            k++;
        end
        check(name, state, s);
    endtask

    initial begin
        int base_rd;
        int base_wr;
        int bad;
        fif.full_out = 1'b0;

        // Reset and idle with both FIFOs empty.
        do_reset();
        for (int i = 0; i < 10; i++)
            check("idle_outputs_zero",
                  {fif.rd_a, fif.rd_b, fif.wr_out, busy, fif.data_out, tokens_done}, 64'd0);
        check("idle_no_reads", rd_cnt, 0);
        check("idle_state", state, IDLE);

        // Basic add with latency check.
        push_pair(16'h0003, 16'h0004, 16'h0007, 16'h0007);
        wait_writes(1, 30, "basic_write_seen");
        check("basic_latency_rd_to_wr", last_wr_cyc - last_rd_cyc, 3);
        check("basic_tokens_done", tokens_done, 1);
        check("basic_busy_back_low", busy, 1'b0);

        // Wrap vs saturate, zero result, large operands.
        push_pair(16'hFFFF, 16'h0002, 16'h0001, 16'hFFFF);
        push_pair(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        push_pair(16'h8000, 16'h8000, 16'h0000, 16'hFFFF);
        push_pair(16'h1234, 16'h4321, 16'h5555, 16'h5555);
        wait_writes(5, 60, "vectors_writes_seen");
        tick(3);
        check("vectors_tokens_done", tokens_done, 5);
        check("sat_tokens_done", tokens_done_s, 5);
        check("data_out_holds", fif.data_out, 16'h5555);

        // Backpressure: hold full for 20 cycles in WAIT_OUT.
        fif.full_out = 1'b1;
        push_pair(16'h00AA, 16'h0055, 16'h00FF, 16'h00FF);
        wait_state(WAIT_OUT, 20, "bp_reach_wait_out");
        base_rd = rd_cnt;
        base_wr = wr_cnt;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (fif.wr_out || !busy || state != WAIT_OUT) bad++;
            tick();
        end
        check("bp_held_cycles_bad", bad, 0);
        check("bp_no_extra_reads", rd_cnt, base_rd);
        check("bp_no_write_while_full", wr_cnt, base_wr);
        fif.full_out = 1'b0;
        tick(10);
        check("bp_single_write", wr_cnt, base_wr + 1);
        check("bp_tokens_done", tokens_done, 6);

        // Unbalanced inputs: A has tokens, B empty for 30 cycles.
        do_reset();
        base_rd = rd_cnt;
        base_wr = wr_cnt;
        qa.push_back(16'd1);
        qa.push_back(16'd2);
        qa.push_back(16'd3);
        tick(30);
        check("unbal_no_reads", rd_cnt, base_rd);
        check("unbal_busy_low", busy, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            qb.push_back(16'(10 * i));
            exp_q.push_back(16'(11 * i));
            exp_sat_q.push_back(16'(11 * i));
        end
        wait_writes(base_wr + 3, 60, "unbal_writes_seen");
        tick(3);
        check("unbal_tokens_done", tokens_done, 3);

        // Reset while a result waits in WAIT_OUT.
        fif.full_out = 1'b1;
        push_pair(16'h0005, 16'h0006, 16'h000B, 16'h000B);
        wait_state(WAIT_OUT, 20, "rst_reach_wait_out");
        base_wr = wr_cnt;
        reset = 1'b1;
        exp_q.delete();
        exp_sat_q.delete();
        tick();
        check("rst_state_idle", state, IDLE);
        check("rst_outputs_zero", {fif.wr_out, busy, fif.data_out, tokens_done}, 64'd0);
        reset = 1'b0;
        fif.full_out = 1'b0;
        tick(10);
        check("rst_pending_dropped", wr_cnt, base_wr);
        check("sb_wrap_drained", exp_q.size(), 0);
        check("sb_sat_drained", exp_sat_q.size(), 0);
        check("sat_write_count", wr_sat_cnt, wr_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
